// File: rtl/rgb_ddr_pkg.sv
// Shared definitions for the pixel-FIFO to DDR burst writer: FSM encoding,
// MCB command constants and word/byte helpers.
package rgb_ddr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        CMD   = 2'd3
    } state_t;

    localparam logic [2:0] WR                = 3'b000;
    localparam int         MCB_WR_FIFO_DEPTH = 64;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rgb_ddr_addr_gen.sv
// Frame-buffer walker: word index, wrap detection, deferred frame_start and
// byte-address generation. RGB_DDR_DOUBLE_BUFFER_EN adds a ping-pong buffer select.
module rgb_ddr_addr_gen
    import rgb_ddr_pkg::*;
#(
    parameter int DDR_DATA_WIDTH  = 32,
    parameter int BURST_LEN       = 32,
    parameter int ADDR_WIDTH      = 30,
    parameter int FRAME_BASE_ADDR = 0,
    parameter int FRAME_WORDS     = 307200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idle,
    input  logic                  advance,
    input  logic                  frame_start,
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
    output logic                  buffer_sel,
`endif
    output logic                  last_burst,
    output logic [ADDR_WIDTH-1:0] byte_addr
);

    localparam int IDX_W = $clog2(FRAME_WORDS + 1);
    localparam int BPW   = bytes_per_word(DDR_DATA_WIDTH);
    localparam logic [IDX_W:0] BL_EXT = (IDX_W + 1)'(BURST_LEN);
    localparam logic [IDX_W:0] FW_EXT = (IDX_W + 1)'(FRAME_WORDS);

    logic [IDX_W-1:0] word_idx;
    logic             restart_pending;

    assign last_burst = ({1'b0, word_idx} + BL_EXT) == FW_EXT;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx        <= '0;
            restart_pending <= 1'b0;
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
            buffer_sel      <= 1'b0;
`endif
        end else if (idle && (restart_pending || frame_start)) begin
            // Restart only between bursts so a burst in flight is never split.
            word_idx        <= '0;
            restart_pending <= 1'b0;
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
            buffer_sel      <= 1'b0;
`endif
        end else begin
            if (frame_start) begin
                restart_pending <= 1'b1;
            end
            if (advance) begin
                if (last_burst) begin
                    word_idx <= '0;
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
                    buffer_sel <= ~buffer_sel;
`endif
                end else begin
                    word_idx <= word_idx + BL_EXT[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        byte_addr = ADDR_WIDTH'(FRAME_BASE_ADDR) + ADDR_WIDTH'(word_idx) * ADDR_WIDTH'(BPW);
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
        if (buffer_sel) begin
            byte_addr = byte_addr + ADDR_WIDTH'(FRAME_WORDS * BPW);
        end
`endif
    end

endmodule

// File: rtl/rgb_ddr_burst_writer.sv
// Drains 24-bit pixels from the receive FIFO into fixed-length MCB write bursts
// over a linear frame buffer. Define RGB_DDR_DOUBLE_BUFFER_EN for ping-pong frames.
module rgb_ddr_burst_writer
    import rgb_ddr_pkg::*;
#(
    parameter int RGB_WIDTH        = 24,
    parameter int DDR_DATA_WIDTH   = 32,
    parameter int BURST_LEN        = 32,
    parameter int DATA_COUNT_WIDTH = 13,
    parameter int ADDR_WIDTH       = 30,
    parameter int FRAME_BASE_ADDR  = 0,
    parameter int FRAME_WORDS      = 307200
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        frame_start,
    input  logic [RGB_WIDTH-1:0]        fifo_data_out,
    input  logic [DATA_COUNT_WIDTH-1:0] fifo_rd_data_count,
    input  logic                        fifo_empty,
    output logic                        fifo_read_enable,
    output logic                        mcb_cmd_en,
    output logic [2:0]                  mcb_cmd_instr,
    output logic [5:0]                  mcb_cmd_bl,
    output logic [ADDR_WIDTH-1:0]       mcb_cmd_byte_addr,
    input  logic                        mcb_cmd_full,
    output logic                        mcb_wr_en,
    output logic [DDR_DATA_WIDTH-1:0]   mcb_wr_data,
    output logic [DDR_DATA_WIDTH/8-1:0] mcb_wr_mask,
    input  logic [6:0]                  mcb_wr_count,
    input  logic                        mcb_wr_underrun,
    output logic                        frame_done,
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
    output logic                        active_buffer,
`endif
    output logic                        error
);

    localparam logic [6:0] BEAT_LAST = 7'(BURST_LEN - 1);

    state_t                  state;
    logic [6:0]              beat;
    logic                    start_ok;
    logic                    advance;
    logic                    last_burst;
    logic [ADDR_WIDTH-1:0]   next_addr;

    assign mcb_cmd_instr = WR;
    assign mcb_cmd_bl    = 6'(BURST_LEN - 1);
    assign mcb_wr_mask   = '0;

    // FIFO read data arrives one cycle after the pop, exactly when mcb_wr_en is
    // high, so it is forwarded directly rather than costing another cycle.
    assign mcb_wr_data = mcb_wr_en ? DDR_DATA_WIDTH'(fifo_data_out) : '0;

    // A full burst must already sit in the pixel FIFO and fit in the MCB FIFO.
    assign start_ok = enable
                   && (fifo_rd_data_count >= DATA_COUNT_WIDTH'(BURST_LEN))
                   && (({1'b0, mcb_wr_count} + 8'(BURST_LEN)) <= 8'(MCB_WR_FIFO_DEPTH));

    assign advance = (state == CMD) && !mcb_cmd_full;

    rgb_ddr_addr_gen #(
        .DDR_DATA_WIDTH  (DDR_DATA_WIDTH),
        .BURST_LEN       (BURST_LEN),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .FRAME_BASE_ADDR (FRAME_BASE_ADDR),
        .FRAME_WORDS     (FRAME_WORDS)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .idle        (state == IDLE),
        .advance     (advance),
        .frame_start (frame_start),
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
        .buffer_sel  (active_buffer),
`endif
        .last_burst  (last_burst),
        .byte_addr   (next_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            beat              <= '0;
            fifo_read_enable  <= 1'b0;
            mcb_wr_en         <= 1'b0;
            mcb_cmd_en        <= 1'b0;
            mcb_cmd_byte_addr <= '0;
            frame_done        <= 1'b0;
            error             <= 1'b0;
        end else begin
            mcb_wr_en  <= fifo_read_enable;
            mcb_cmd_en <= 1'b0;
            frame_done <= 1'b0;

            if (mcb_wr_underrun || (fifo_empty && fifo_read_enable)) begin
                error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state            <= FILL;
                        beat             <= '0;
                        fifo_read_enable <= 1'b1;
                    end
                end
                FILL: begin
                    if (beat == BEAT_LAST) begin
                        state            <= DRAIN;
                        beat             <= '0;
                        fifo_read_enable <= 1'b0;
                    end else begin
                        beat <= beat + 7'd1;
                    end
                end
                DRAIN: begin
                    state <= CMD;
                end
                CMD: begin
                    if (!mcb_cmd_full) begin
                        state             <= IDLE;
                        mcb_cmd_en        <= 1'b1;
                        mcb_cmd_byte_addr <= next_addr;
                        frame_done        <= last_burst;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_ddr_burst_writer.sv
// Scoreboard bench for rgb_ddr_burst_writer with BURST_LEN=4, FRAME_WORDS=8;
// also builds with RGB_DDR_DOUBLE_BUFFER_EN defined.
module tb_rgb_ddr_burst_writer;

    localparam int BL = 4;
    localparam int FW = 8;
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
    localparam logic [29:0] BUF1 = 30'h20;
`else
    localparam logic [29:0] BUF1 = 30'h00;
`endif

    typedef struct packed {
        logic [29:0] addr;
        logic        fd;
    } cmd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic [23:0] fifo_data_out = '0;
    logic [12:0] fifo_rd_data_count = '0;
    logic        fifo_empty = 1'b0;
    logic        fifo_read_enable;
    logic        mcb_cmd_en;
    logic [2:0]  mcb_cmd_instr;
    logic [5:0]  mcb_cmd_bl;
    logic [29:0] mcb_cmd_byte_addr;
    logic        mcb_cmd_full = 1'b0;
    logic        mcb_wr_en;
    logic [31:0] mcb_wr_data;
    logic [3:0]  mcb_wr_mask;
    logic [6:0]  mcb_wr_count = '0;
    logic        mcb_wr_underrun = 1'b0;
    logic        frame_done;
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
    logic        active_buffer;
`endif
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd_cnt = 0;
    int cmd_cyc = 0;
    int rd_cnt = 0;
    int pix_n = 0;
    logic rst_q = 1'b1;
    logic prev_rd = 1'b0;

    logic [31:0] wr_q[$];
    cmd_exp_t    cmd_q[$];

    rgb_ddr_burst_writer #(
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .frame_start        (frame_start),
        .fifo_data_out      (fifo_data_out),
        .fifo_rd_data_count (fifo_rd_data_count),
        .fifo_empty         (fifo_empty),
        .fifo_read_enable   (fifo_read_enable),
        .mcb_cmd_en         (mcb_cmd_en),
        .mcb_cmd_instr      (mcb_cmd_instr),
        .mcb_cmd_bl         (mcb_cmd_bl),
        .mcb_cmd_byte_addr  (mcb_cmd_byte_addr),
        .mcb_cmd_full       (mcb_cmd_full),
        .mcb_wr_en          (mcb_wr_en),
        .mcb_wr_data        (mcb_wr_data),
        .mcb_wr_mask        (mcb_wr_mask),
        .mcb_wr_count       (mcb_wr_count),
        .mcb_wr_underrun    (mcb_wr_underrun),
        .frame_done         (frame_done),
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
        .active_buffer      (active_buffer),
`endif
        .error              (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel FIFO model: each pop presents a fresh pixel one cycle later.
    initial begin
        logic [23:0] pix;
        forever begin
            @(negedge clk);
            if (fifo_read_enable) begin
                @(posedge clk);
                #1;
                pix = {8'(pix_n), 8'hC3, ~8'(pix_n)};
                fifo_data_out = pix;
                wr_q.push_back({8'h00, pix});
                pix_n++;
            end
        end
    end

    // Monitor: compares every DUT write beat and command against the queues.
    initial begin
        cmd_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_q && (mcb_wr_en || prev_rd)) begin
                check("wr_en_latency", 64'(mcb_wr_en), 64'(prev_rd));
            end
            if (mcb_wr_en) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wr: got data %0h expected no write", mcb_wr_data);
                end else begin
                    check("wr_data", 64'(mcb_wr_data), 64'(wr_q.pop_front()));
                end
            end
            if (mcb_cmd_en) begin
                cmd_cnt++;
                cmd_cyc = cyc;
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cmd: got addr %0h expected no command", mcb_cmd_byte_addr);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_addr", 64'(mcb_cmd_byte_addr), 64'(e.addr));
                    check("frame_done", 64'(frame_done), 64'(e.fd));
                end
            end else if (frame_done) begin
                check("frame_done_without_cmd", 64'(frame_done), 64'd0);
            end
            if (fifo_read_enable) rd_cnt++;
            prev_rd = fifo_read_enable;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_rd(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (fifo_read_enable) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: got no fifo_read_enable expected one within 20 cycles", name);
        end
    endtask

    task automatic wait_cmd(input string name, input int n0);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); #1;
            if (cmd_cnt != n0) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s: got no mcb_cmd_en expected one within 40 cycles", name);
        end
    endtask

    task automatic burst(input string name, input logic [29:0] addr, input logic fd);
        int n0 = cmd_cnt;
        cmd_q.push_back('{addr: addr, fd: fd});
        fifo_rd_data_count = 13'd4;
        wait_rd(name);
        fifo_rd_data_count = 13'd0;
        wait_cmd(name, n0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  64'(fifo_read_enable), 64'd0);
        check({tag, "_wr_en"},  64'(mcb_wr_en), 64'd0);
        check({tag, "_cmd_en"}, 64'(mcb_cmd_en), 64'd0);
        check({tag, "_addr"},   64'(mcb_cmd_byte_addr), 64'd0);
        check({tag, "_wr_data"},64'(mcb_wr_data), 64'd0);
        check({tag, "_fdone"},  64'(frame_done), 64'd0);
        check({tag, "_error"},  64'(error), 64'd0);
        check({tag, "_bl"},     64'(mcb_cmd_bl), 64'd3);
        check({tag, "_instr"},  64'(mcb_cmd_instr), 64'd0);
        check({tag, "_mask"},   64'(mcb_wr_mask), 64'd0);
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
        check({tag, "_active_buffer"}, 64'(active_buffer), 64'd0);
`endif
    endtask

    initial begin
        int n0;
        int r0;
        int c;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk); #1;

        // Basic bursts across a frame wrap.
        burst("b1", 30'h00, 1'b0);
        burst("b2", 30'h10, 1'b1);
        burst("b3", BUF1 + 30'h00, 1'b0);
`ifdef RGB_DDR_DOUBLE_BUFFER_EN
        check("active_buffer_after_wrap", 64'(active_buffer), 64'd1);
`endif

        // Start conditions not met: no pop, no command.
        r0 = rd_cnt; n0 = cmd_cnt;
        fifo_rd_data_count = 13'd3;
        repeat (10) @(negedge clk);
        #1;
        check("no_pop_count3", 64'(rd_cnt), 64'(r0));
        fifo_rd_data_count = 13'd4;
        mcb_wr_count = 7'd61;
        repeat (10) @(negedge clk);
        #1;
        check("no_pop_wrcount61", 64'(rd_cnt), 64'(r0));
        check("no_cmd_blocked", 64'(cmd_cnt), 64'(n0));
        cmd_q.push_back('{addr: BUF1 + 30'h10, fd: 1'b1});
        mcb_wr_count = 7'd60;
        wait_rd("wrcount60");
        fifo_rd_data_count = 13'd0;
        wait_cmd("wrcount60", n0);
        mcb_wr_count = 7'd0;

        // frame_start during FILL: this burst completes, the next restarts at 0.
        n0 = cmd_cnt;
        cmd_q.push_back('{addr: 30'h00, fd: 1'b0});
        fifo_rd_data_count = 13'd4;
        wait_rd("fs_burst");
        fifo_rd_data_count = 13'd0;
        frame_start = 1'b1;
        @(negedge clk); #1;
        frame_start = 1'b0;
        wait_cmd("fs_burst", n0);
        burst("fs_next", 30'h00, 1'b0);

        // Command FIFO full for 5 CMD cycles.
        n0 = cmd_cnt;
        mcb_cmd_full = 1'b1;
        cmd_q.push_back('{addr: 30'h10, fd: 1'b1});
        fifo_rd_data_count = 13'd4;
        wait_rd("cmd_full");
        c = cyc;
        fifo_rd_data_count = 13'd0;
        while (cyc < c + 10) @(negedge clk);
        #1;
        mcb_cmd_full = 1'b0;
        wait_cmd("cmd_full", n0);
        check("cmd_full_delay", 64'(cmd_cyc), 64'(c + 11));
        repeat (5) @(negedge clk);
        #1;
        check("cmd_full_single_pulse", 64'(cmd_cnt), 64'(n0 + 1));

        // Reset in the middle of FILL.
        fifo_rd_data_count = 13'd4;
        wait_rd("rst_mid_fill");
        fifo_rd_data_count = 13'd0;
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        check_reset_outputs("rst_mid_fill");
        @(negedge clk); #1;
        rst = 1'b0;
        wr_q.delete();
        @(negedge clk); #1;

        // Sticky error from a pop while the FIFO reports empty.
        check("error_clear_before", 64'(error), 64'd0);
        n0 = cmd_cnt;
        cmd_q.push_back('{addr: 30'h00, fd: 1'b0});
        fifo_rd_data_count = 13'd4;
        wait_rd("empty_err");
        fifo_empty = 1'b1;
        @(negedge clk); #1;
        fifo_empty = 1'b0;
        fifo_rd_data_count = 13'd0;
        wait_cmd("empty_err", n0);
        check("error_empty_pop", 64'(error), 64'd1);
        repeat (5) @(negedge clk);
        #1;
        check("error_sticky_empty", 64'(error), 64'd1);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("error_after_rst", 64'(error), 64'd0);

        // Sticky error from an MCB underrun pulse.
        mcb_wr_underrun = 1'b1;
        @(negedge clk); #1;
        mcb_wr_underrun = 1'b0;
        check("error_underrun", 64'(error), 64'd1);
        repeat (5) @(negedge clk);
        #1;
        check("error_sticky_underrun", 64'(error), 64'd1);

        repeat (5) @(negedge clk);
        #1;
        check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
